// File: rtl/mem_port_arbiter_if.sv
// Request/grant, read-return and RAM-pin bundle shared by the CPU port, the VGA fetch port and the RAM.
// The master side is the requesters plus the RAM; the slave side is the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [1:0]        owner;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output vga_req, vga_addr,
        input  vga_gnt, vga_rvalid, vga_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata,
        input  owner
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  vga_req, vga_addr,
        output vga_gnt, vga_rvalid, vga_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata,
        output owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: VGA fetch has priority up to a burst limit, and the CPU wait is bounded.
// Grants are combinational; read data returns one cycle after the grant alongside a 1-cycle rvalid pulse.
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int VGA_BURST    = 4,
    parameter int CPU_MAX_WAIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int RUN_W  = $clog2(VGA_BURST + 1);
    localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(VGA_BURST);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_VGA  = 2'b10
    } owner_e;

    owner_e            owner_q, owner_d;
    logic [RUN_W-1:0]  vga_run_q, vga_run_d;
    logic [WAIT_W-1:0] cpu_wait_q, cpu_wait_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              vga_rvalid_q, vga_rvalid_d;

    logic              cpu_gnt_c;
    logic              vga_gnt_c;
    logic              force_cpu;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= OWN_IDLE;
            vga_run_q    <= '0;
            cpu_wait_q   <= '0;
            cpu_rvalid_q <= 1'b0;
            vga_rvalid_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            vga_run_q    <= vga_run_d;
            cpu_wait_q   <= cpu_wait_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            vga_rvalid_q <= vga_rvalid_d;
        end
    end

    // Next state: owner follows this cycle's grant; counters saturate at their limits
    always_comb begin
        owner_d      = OWN_IDLE;
        vga_run_d    = '0;
        cpu_wait_d   = '0;
        cpu_rvalid_d = cpu_gnt_c & ~bus.cpu_we;
        vga_rvalid_d = vga_gnt_c;

        if (cpu_gnt_c) begin
            owner_d = OWN_CPU;
        end else if (vga_gnt_c) begin
            owner_d = OWN_VGA;
        end

        if (vga_gnt_c) begin
            vga_run_d = (vga_run_q == RUN_MAX) ? vga_run_q : vga_run_q + 1'b1;
        end

        if (bus.cpu_req && !cpu_gnt_c) begin
            cpu_wait_d = (cpu_wait_q == WAIT_MAX) ? cpu_wait_q : cpu_wait_q + 1'b1;
        end
    end

    // Outputs: grant decision and RAM pin muxing; reset blocks grants and hides stale rvalid
    always_comb begin
        force_cpu = (vga_run_q == RUN_MAX) || (cpu_wait_q == WAIT_MAX);
        cpu_gnt_c = 1'b0;
        vga_gnt_c = 1'b0;

        if (!reset) begin
            if (bus.cpu_req && (!bus.vga_req || force_cpu)) begin
                cpu_gnt_c = 1'b1;
            end else if (bus.vga_req) begin
                vga_gnt_c = 1'b1;
            end
        end

        bus.cpu_gnt    = cpu_gnt_c;
        bus.vga_gnt    = vga_gnt_c;
        bus.cpu_rvalid = cpu_rvalid_q & ~reset;
        bus.vga_rvalid = vga_rvalid_q & ~reset;
        bus.cpu_rdata  = bus.ram_rdata;
        bus.vga_rdata  = bus.ram_rdata;
        bus.ram_we     = cpu_gnt_c & bus.cpu_we;
        bus.ram_wdata  = bus.cpu_wdata;
        bus.owner      = reset ? OWN_IDLE : owner_q;

        if (cpu_gnt_c) begin
            bus.ram_addr = bus.cpu_addr;
        end else if (vga_gnt_c) begin
            bus.ram_addr = bus.vga_addr;
        end else begin
            bus.ram_addr = '0;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural RAM, per-scenario grant checks and a read-response scoreboard.
// A second instance with a long burst and short CPU wait limit shares the same stimulus.
module tb_mem_port_arbiter;
    logic clk;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    exp_t cpu_q[$];
    exp_t vga_q[$];

    logic [15:0] mem [0:65535];

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus2 ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .VGA_BURST(4), .CPU_MAX_WAIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .VGA_BURST(16), .CPU_MAX_WAIT(3)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    assign bus2.cpu_req   = bus.cpu_req;
    assign bus2.cpu_we    = bus.cpu_we;
    assign bus2.cpu_addr  = bus.cpu_addr;
    assign bus2.cpu_wdata = bus.cpu_wdata;
    assign bus2.vga_req   = bus.vga_req;
    assign bus2.vga_addr  = bus.vga_addr;
    assign bus2.ram_rdata = 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM, read-first, one-cycle registered read
    always @(posedge clk) begin
        bus.ram_rdata <= mem[bus.ram_addr];
        if (bus.ram_we) mem[bus.ram_addr] = bus.ram_wdata;
    end

    // Read-response scoreboard
    always @(negedge clk) begin
        #2;
        if (cpu_q.size() > 0 && cpu_q[0].cyc == cyc) begin
            checks++;
            if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== cpu_q[0].data) begin
                errors++;
                $display("FAIL cpu_rsp cyc %0d: rvalid=%b rdata=%h, expected rvalid=1 rdata=%h",
                         cyc, bus.cpu_rvalid, bus.cpu_rdata, cpu_q[0].data);
            end
            void'(cpu_q.pop_front());
        end else if (bus.cpu_rvalid !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL cpu_rvalid_spurious cyc %0d: rvalid=%b, expected 0", cyc, bus.cpu_rvalid);
        end
        if (vga_q.size() > 0 && vga_q[0].cyc == cyc) begin
            checks++;
            if (bus.vga_rvalid !== 1'b1 || bus.vga_rdata !== vga_q[0].data) begin
                errors++;
                $display("FAIL vga_rsp cyc %0d: rvalid=%b rdata=%h, expected rvalid=1 rdata=%h",
                         cyc, bus.vga_rvalid, bus.vga_rdata, vga_q[0].data);
            end
            void'(vga_q.pop_front());
        end else if (bus.vga_rvalid !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL vga_rvalid_spurious cyc %0d: rvalid=%b, expected 0", cyc, bus.vga_rvalid);
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0055; bus.cpu_wdata = 16'hBEEF;
        bus.vga_req = 1'b1; bus.vga_addr = 16'h0066;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.cpu_gnt !== 1'b0 || bus.vga_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: cpu_gnt=%b vga_gnt=%b, expected 0 0", bus.cpu_gnt, bus.vga_gnt);
        end
        checks++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_ram: ram_we=%b ram_addr=%h, expected 0 0000", bus.ram_we, bus.ram_addr);
        end
        checks++;
        if (bus.owner !== 2'b00) begin
            errors++;
            $display("FAIL reset_owner: owner=%b, expected 00", bus.owner);
        end
        bus.cpu_req = 1'b0; bus.vga_req = 1'b0; bus.cpu_we = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic test_cpu_read();
        mem[16'h0010] = 16'h00E9;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        #1;
        checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.vga_gnt !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_gnt: cpu_gnt=%b vga_gnt=%b, expected 1 0", bus.cpu_gnt, bus.vga_gnt);
        end
        checks++;
        if (bus.ram_addr !== 16'h0010 || bus.ram_we !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_ram: ram_addr=%h ram_we=%b, expected 0010 0", bus.ram_addr, bus.ram_we);
        end
        cpu_q.push_back('{cyc + 1, 16'h00E9});
        @(negedge clk);
        bus.cpu_req = 1'b0;
        #1;
        checks++;
        if (bus.owner !== 2'b01 || bus.cpu_gnt !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_owner: owner=%b cpu_gnt=%b, expected 01 0", bus.owner, bus.cpu_gnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.owner !== 2'b00) begin
            errors++;
            $display("FAIL idle_owner: owner=%b, expected 00", bus.owner);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0020; bus.cpu_wdata = 16'h0064;
        #1;
        checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 16'h0020 ||
            bus.ram_wdata !== 16'h0064) begin
            errors++;
            $display("FAIL write_issue: gnt=%b we=%b addr=%h wdata=%h, expected 1 1 0020 0064",
                     bus.cpu_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        @(negedge clk);
        bus.cpu_we = 1'b0;
        #1;
        checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.ram_we !== 1'b0) begin
            errors++;
            $display("FAIL raw_read_issue: gnt=%b we=%b, expected 1 0", bus.cpu_gnt, bus.ram_we);
        end
        cpu_q.push_back('{cyc + 1, 16'h0064});
        @(negedge clk);
        bus.cpu_req = 1'b0;
        #1;
    endtask

    task automatic test_both_held();
        logic exp_c;
        logic [1:0] exp_owner;
        mem[16'h0030] = 16'h1234;
        mem[16'h0040] = 16'h5678;
        exp_owner = 2'b00;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0030;
        bus.vga_req = 1'b1; bus.vga_addr = 16'h0040;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            exp_c = ((i % 5) == 4);
            checks++;
            if (bus.cpu_gnt !== exp_c || bus.vga_gnt !== !exp_c) begin
                errors++;
                $display("FAIL both_held_gnt[%0d]: cpu_gnt=%b vga_gnt=%b, expected %b %b",
                         i, bus.cpu_gnt, bus.vga_gnt, exp_c, !exp_c);
            end
            checks++;
            if (bus.owner !== exp_owner) begin
                errors++;
                $display("FAIL both_held_owner[%0d]: owner=%b, expected %b", i, bus.owner, exp_owner);
            end
            if (exp_c) cpu_q.push_back('{cyc + 1, 16'h1234});
            else       vga_q.push_back('{cyc + 1, 16'h5678});
            exp_owner = exp_c ? 2'b01 : 2'b10;
        end
        @(negedge clk);
        bus.cpu_req = 1'b0; bus.vga_req = 1'b0;
        #1;
    endtask

    task automatic test_short_burst();
        logic exp_c2;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0030;
        bus.vga_req = 1'b1; bus.vga_addr = 16'h0040;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            exp_c2 = ((i % 4) == 3);
            checks++;
            if (bus2.cpu_gnt !== exp_c2 || bus2.vga_gnt !== !exp_c2) begin
                errors++;
                $display("FAIL short_burst_gnt[%0d]: cpu_gnt=%b vga_gnt=%b, expected %b %b",
                         i, bus2.cpu_gnt, bus2.vga_gnt, exp_c2, !exp_c2);
            end
            if ((i % 5) == 4) cpu_q.push_back('{cyc + 1, 16'h1234});
            else              vga_q.push_back('{cyc + 1, 16'h5678});
        end
        @(negedge clk);
        bus.cpu_req = 1'b0; bus.vga_req = 1'b0;
        #1;
    endtask

    task automatic test_vga_stream();
        for (int i = 0; i < 8; i++) mem[16'h0100 + i] = 16'hA100 + 16'(i);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.vga_req = 1'b1; bus.vga_addr = 16'h0100 + 16'(i);
            #1;
            checks++;
            if (bus.vga_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0 || bus.ram_addr !== 16'h0100 + 16'(i)) begin
                errors++;
                $display("FAIL vga_stream_gnt[%0d]: vga_gnt=%b cpu_gnt=%b ram_addr=%h, expected 1 0 %h",
                         i, bus.vga_gnt, bus.cpu_gnt, bus.ram_addr, 16'h0100 + 16'(i));
            end
            vga_q.push_back('{cyc + 1, 16'hA100 + 16'(i)});
        end
        @(negedge clk);
        bus.vga_req = 1'b0;
        #1;
        checks++;
        if (bus.vga_gnt !== 1'b0 || bus.ram_addr !== 16'h0000 || bus.ram_we !== 1'b0) begin
            errors++;
            $display("FAIL no_req_idle: vga_gnt=%b ram_addr=%h ram_we=%b, expected 0 0000 0",
                     bus.vga_gnt, bus.ram_addr, bus.ram_we);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        #1;
        checks++;
        if (bus.cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre_gnt: cpu_gnt=%b, expected 1", bus.cpu_gnt);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.cpu_gnt !== 1'b0 || bus.vga_gnt !== 1'b0 || bus.cpu_rvalid !== 1'b0 || bus.owner !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset: cpu_gnt=%b vga_gnt=%b cpu_rvalid=%b owner=%b, expected 0 0 0 00",
                     bus.cpu_gnt, bus.vga_gnt, bus.cpu_rvalid, bus.owner);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.owner !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_gnt: cpu_gnt=%b owner=%b, expected 1 00", bus.cpu_gnt, bus.owner);
        end
        cpu_q.push_back('{cyc + 1, 16'h00E9});
        @(negedge clk);
        bus.cpu_req = 1'b0;
        #1;
        checks++;
        if (bus.owner !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_owner: owner=%b, expected 01", bus.owner);
        end
    endtask

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.vga_req = 1'b0; bus.vga_addr = '0;
        reset = 1'b1;
        test_reset();
        test_cpu_read();
        test_write_read();
        test_both_held();
        test_short_burst();
        test_vga_stream();
        test_reset_mid();
        repeat (3) @(negedge clk);
        #3;
        checks++;
        if (cpu_q.size() != 0 || vga_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: cpu_q=%0d vga_q=%0d left, expected 0 0", cpu_q.size(), vga_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
